board_access_arbiter: RTL and testbench

- Owns the single port of the board cell RAM and shares it between three requesters:
  - seed_gen stream writes;
  - cursor-click toggles, done as read-modify-write;
  - the generation step engine.
- Also schedules generation steps from the user speed setting, counted in vsync frames.
- Sits between user_interface/seed_gen and the life_logic board memory in the 25 MHz domain.

---
 rtl/board_access_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_board_access_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_access_arbiter.sv
// Board RAM port arbiter. Shares the single board cell RAM port between seed
// streaming, cursor-click read-modify-write toggles and the generation step
// engine, and schedules generation steps from the speed setting in vsync frames.
module board_access_arbiter #(
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned SPEED_W = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [SPEED_W-1:0] speed_in,
    input  logic              vsync_in,
    input  logic              seed_req_in,
    output logic              seed_gnt_out,
    input  logic              seed_wr_in,
    input  logic [ADDR_W-1:0] seed_addr_in,
    input  logic              seed_alive_in,
    input  logic              click_in,
    input  logic [ADDR_W-1:0] click_addr_in,
    output logic              click_drop_out,
    output logic              step_start_out,
    input  logic              step_done_in,
    input  logic [ADDR_W-1:0] step_addr_in,
    input  logic              step_wr_in,
    input  logic              step_alive_in,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic              mem_wr_out,
    output logic              mem_data_out,
    input  logic              mem_rd_in,
    output logic              busy_out
);

    typedef enum logic [2:0] {
        StIdle,
        StSeed,
        StClkRd,
        StClkWait,
        StClkWr,
        StStep
    } state_e;

    // Frame period is 2^SPEED_W - speed; needs one extra bit for the full-scale value.
    localparam logic [SPEED_W:0] FullScale = {1'b1, {SPEED_W{1'b0}}};

    state_e              state_q, state_d;
    logic                vsync_q;
    logic [SPEED_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic                tick_pending_q, tick_pending_d;
    logic                click_pending_q, click_pending_d;
    logic [ADDR_W-1:0]   click_addr_q, click_addr_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_wr_q, mem_wr_d;
    logic                mem_data_q, mem_data_d;

    logic                start;
    logic                tick_take;
    logic                click_clear;
    logic                frame_tick;
    logic [SPEED_W:0]    period;
    logic [SPEED_W:0]    cnt_inc;

    assign frame_tick = vsync_q & ~vsync_in;
    assign period     = FullScale - {1'b0, speed_in};
    assign cnt_inc    = {1'b0, frame_cnt_q} + (SPEED_W + 1)'(1);

    // Arbitration FSM: next state, RAM port next values and step start strobe.
    always_comb begin
        state_d     = state_q;
        start       = 1'b0;
        tick_take   = 1'b0;
        click_clear = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wr_d    = 1'b0;
        mem_data_d  = mem_data_q;
        case (state_q)
            StIdle: begin
                if (seed_req_in) begin
                    state_d = StSeed;
                end else if (click_pending_q) begin
                    state_d = StClkRd;
                end else if (tick_pending_q) begin
                    state_d   = StStep;
                    start     = 1'b1;
                    tick_take = 1'b1;
                end
            end
            StSeed: begin
                mem_addr_d = seed_addr_in;
                mem_wr_d   = seed_wr_in;
                mem_data_d = seed_alive_in;
                if (!seed_req_in) state_d = StIdle;
            end
            StClkRd: begin
                mem_addr_d = click_addr_q;
                state_d    = StClkWait;
            end
            StClkWait: begin
                state_d = StClkWr;
            end
            StClkWr: begin
                // Read data for click_addr_q arrives this cycle; write back the toggle.
                mem_addr_d  = click_addr_q;
                mem_wr_d    = 1'b1;
                mem_data_d  = ~mem_rd_in;
                click_clear = 1'b1;
                state_d     = StIdle;
            end
            StStep: begin
                mem_addr_d = step_addr_in;
                mem_wr_d   = step_wr_in;
                mem_data_d = step_alive_in;
                if (step_done_in) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Click latch: one pending click; a click landing on the clearing cycle is kept.
    always_comb begin
        click_pending_d = click_pending_q;
        click_addr_d    = click_addr_q;
        if (click_in && (!click_pending_q || click_clear)) begin
            click_pending_d = 1'b1;
            click_addr_d    = click_addr_in;
        end else if (click_clear) begin
            click_pending_d = 1'b0;
        end
    end

    // Step scheduler: count frames up to the period; a fresh fire wins over consumption.
    always_comb begin
        frame_cnt_d    = frame_cnt_q;
        tick_pending_d = tick_pending_q & ~tick_take;
        if (speed_in == '0) begin
            frame_cnt_d    = '0;
            tick_pending_d = 1'b0;
        end else if (frame_tick) begin
            if (cnt_inc >= period) begin
                frame_cnt_d    = '0;
                tick_pending_d = 1'b1;
            end else begin
                frame_cnt_d = cnt_inc[SPEED_W-1:0];
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q         <= StIdle;
            vsync_q         <= 1'b1;
            frame_cnt_q     <= '0;
            tick_pending_q  <= 1'b0;
            click_pending_q <= 1'b0;
            click_addr_q    <= '0;
            mem_addr_q      <= '0;
            mem_wr_q        <= 1'b0;
            mem_data_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            vsync_q         <= vsync_in;
            frame_cnt_q     <= frame_cnt_d;
            tick_pending_q  <= tick_pending_d;
            click_pending_q <= click_pending_d;
            click_addr_q    <= click_addr_d;
            mem_addr_q      <= mem_addr_d;
            mem_wr_q        <= mem_wr_d;
            mem_data_q      <= mem_data_d;
        end
    end

    assign seed_gnt_out   = (state_q == StSeed);
    assign busy_out       = (state_q != StIdle);
    // Strobes are masked during reset so the engine never sees a stray start.
    assign step_start_out = start & ~rst_in;
    assign click_drop_out = click_in & click_pending_q & ~click_clear & ~rst_in;
    assign mem_addr_out   = mem_addr_q;
    assign mem_wr_out     = mem_wr_q;
    assign mem_data_out   = mem_data_q;

endmodule

// File: tb/tb_board_access_arbiter.sv
// Directed bench for board_access_arbiter with a behavioural RAM and step engine.
module tb_board_access_arbiter;

    localparam int ADDR_W  = 14;
    localparam int SPEED_W = 4;
    localparam int ENG_LAT = 11;

    logic              clk_in;
    logic              rst_in;
    logic [SPEED_W-1:0] speed_in;
    logic              vsync_in;
    logic              seed_req_in;
    logic              seed_gnt_out;
    logic              seed_wr_in;
    logic [ADDR_W-1:0] seed_addr_in;
    logic              seed_alive_in;
    logic              click_in;
    logic [ADDR_W-1:0] click_addr_in;
    logic              click_drop_out;
    logic              step_start_out;
    logic              step_done_in;
    logic [ADDR_W-1:0] step_addr_in;
    logic              step_wr_in;
    logic              step_alive_in;
    logic [ADDR_W-1:0] mem_addr_out;
    logic              mem_wr_out;
    logic              mem_data_out;
    logic              mem_rd_in;
    logic              busy_out;

    board_access_arbiter #(
        .ADDR_W (ADDR_W),
        .SPEED_W(SPEED_W)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .speed_in      (speed_in),
        .vsync_in      (vsync_in),
        .seed_req_in   (seed_req_in),
        .seed_gnt_out  (seed_gnt_out),
        .seed_wr_in    (seed_wr_in),
        .seed_addr_in  (seed_addr_in),
        .seed_alive_in (seed_alive_in),
        .click_in      (click_in),
        .click_addr_in (click_addr_in),
        .click_drop_out(click_drop_out),
        .step_start_out(step_start_out),
        .step_done_in  (step_done_in),
        .step_addr_in  (step_addr_in),
        .step_wr_in    (step_wr_in),
        .step_alive_in (step_alive_in),
        .mem_addr_out  (mem_addr_out),
        .mem_wr_out    (mem_wr_out),
        .mem_data_out  (mem_data_out),
        .mem_rd_in     (mem_rd_in),
        .busy_out      (busy_out)
    );

    logic ram [0:(1<<ADDR_W)-1];
    int   vectors, errs;
    int   starts, drops, busy_cnt, writes, eng_cnt;
    bit   eng_arm;
    int   snap;

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: record strobes of the current cycle, then model RAM and engine.
    task automatic cyc();
        logic [ADDR_W-1:0] a;
        logic w, d, r;
        #1;
        a = mem_addr_out;
        w = mem_wr_out;
        d = mem_data_out;
        r = rst_in;
        if (step_start_out) begin
            starts++;
            eng_cnt = ENG_LAT;
            eng_arm = 1'b1;
        end
        if (click_drop_out) drops++;
        if (busy_out) busy_cnt++;
        if (mem_wr_out) writes++;
        @(posedge clk_in);
        #1;
        mem_rd_in = ram[a];
        if (w) ram[a] = d;
        step_done_in = 1'b0;
        if (r) begin
            eng_arm = 1'b0;
        end else if (eng_arm) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                step_done_in = 1'b1;
                eng_arm      = 1'b0;
            end
        end
    endtask

    task automatic frame();
        vsync_in = 1'b0;
        cyc();
        vsync_in = 1'b1;
        repeat (24) cyc();
    endtask

    initial begin
        vectors = 0; errs = 0; starts = 0; drops = 0; busy_cnt = 0; writes = 0;
        eng_cnt = 0; eng_arm = 1'b0;
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 1'b0;
        rst_in = 1'b1; speed_in = '0; vsync_in = 1'b1;
        seed_req_in = 1'b0; seed_wr_in = 1'b0; seed_addr_in = '0; seed_alive_in = 1'b0;
        click_in = 1'b0; click_addr_in = '0; step_done_in = 1'b0;
        step_addr_in = '0; step_wr_in = 1'b0; step_alive_in = 1'b0; mem_rd_in = 1'b0;
        repeat (3) cyc();
        rst_in = 1'b0;
        cyc();

        // Reset state
        check("rst_addr", 32'(mem_addr_out), 32'h0);
        check("rst_wr", 32'(mem_wr_out), 32'h0);
        check("rst_data", 32'(mem_data_out), 32'h0);
        check("rst_busy", 32'(busy_out), 32'h0);
        check("rst_gnt", 32'(seed_gnt_out), 32'h0);
        check("rst_start", 32'(step_start_out), 32'h0);
        check("rst_drop", 32'(click_drop_out), 32'h0);

        // Speed 15: one step per frame, each STEP lasting ENG_LAT cycles
        speed_in = 4'd15; starts = 0; busy_cnt = 0;
        repeat (3) frame();
        check("s15_starts", 32'(starts), 32'd3);
        check("s15_busy", 32'(busy_cnt), 32'd33);

        // Speed 13: period 3 frames
        speed_in = 4'd13; starts = 0;
        for (int f = 1; f <= 9; f++) begin
            frame();
            check("s13_starts", 32'(starts), 32'(f / 3));
        end
        speed_in = 4'd0;
        repeat (5) frame();
        check("s0_starts", 32'(starts), 32'd3);

        // Click toggle 0x0105 from 0 to 1, then back to 0
        for (int k = 0; k < 2; k++) begin
            click_addr_in = 14'h0105; click_in = 1'b1;
            cyc();
            click_in = 1'b0;
            cyc();
            cyc();
            check("clk_rd_addr", 32'(mem_addr_out), 32'h0105);
            check("clk_rd_wr", 32'(mem_wr_out), 32'h0);
            check("clk_busy", 32'(busy_out), 32'h1);
            cyc();
            check("clk_wait_wr", 32'(mem_wr_out), 32'h0);
            cyc();
            check("clk_wr", 32'(mem_wr_out), 32'h1);
            check("clk_wr_addr", 32'(mem_addr_out), 32'h0105);
            check("clk_wr_data", 32'(mem_data_out), (k == 0) ? 32'h1 : 32'h0);
            cyc();
            check("clk_ram", 32'(ram[14'h0105]), (k == 0) ? 32'h1 : 32'h0);
            check("clk_idle", 32'(busy_out), 32'h0);
        end

        // Two clicks during STEP: second is dropped, first applied afterwards
        speed_in = 4'd15; drops = 0;
        vsync_in = 1'b0;
        cyc();
        vsync_in = 1'b1;
        cyc();
        cyc();
        check("stp_busy", 32'(busy_out), 32'h1);
        click_addr_in = 14'h0020; click_in = 1'b1;
        cyc();
        click_addr_in = 14'h0030;
        #1;
        check("stp_drop_pulse", 32'(click_drop_out), 32'h1);
        cyc();
        click_in = 1'b0;
        speed_in = 4'd0;
        repeat (25) cyc();
        check("stp_drops", 32'(drops), 32'd1);
        check("stp_ram20", 32'(ram[14'h0020]), 32'h1);
        check("stp_ram30", 32'(ram[14'h0030]), 32'h0);

        // Seed, click and tick together: SEED, then click RMW, then step
        speed_in = 4'd15; starts = 0;
        seed_req_in = 1'b1; click_addr_in = 14'h0040; click_in = 1'b1; vsync_in = 1'b0;
        cyc();
        click_in = 1'b0; vsync_in = 1'b1;
        seed_wr_in = 1'b1; seed_addr_in = 14'h0050; seed_alive_in = 1'b1;
        #1;
        check("pri_gnt", 32'(seed_gnt_out), 32'h1);
        check("pri_nostart", 32'(step_start_out), 32'h0);
        cyc();
        check("seed_addr0", 32'(mem_addr_out), 32'h0050);
        check("seed_wr0", 32'(mem_wr_out), 32'h1);
        check("seed_data0", 32'(mem_data_out), 32'h1);
        seed_addr_in = 14'h0051; seed_alive_in = 1'b0;
        cyc();
        check("seed_addr1", 32'(mem_addr_out), 32'h0051);
        check("seed_data1", 32'(mem_data_out), 32'h0);
        seed_req_in = 1'b0; seed_wr_in = 1'b0;
        #1;
        check("seed_gnt_last", 32'(seed_gnt_out), 32'h1);
        cyc();
        check("seed_gnt_drop", 32'(seed_gnt_out), 32'h0);
        check("seed_wr_off", 32'(mem_wr_out), 32'h0);
        check("pri_click_first", 32'(step_start_out), 32'h0);
        repeat (4) cyc();
        check("pri_clk_wr", 32'(mem_wr_out), 32'h1);
        check("pri_clk_addr", 32'(mem_addr_out), 32'h0040);
        check("pri_then_step", 32'(step_start_out), 32'h1);
        check("pri_starts0", 32'(starts), 32'd0);
        cyc();
        speed_in = 4'd0;
        repeat (15) cyc();
        check("pri_starts1", 32'(starts), 32'd1);
        check("pri_ram40", 32'(ram[14'h0040]), 32'h1);
        check("pri_ram50", 32'(ram[14'h0050]), 32'h1);
        check("pri_ram51", 32'(ram[14'h0051]), 32'h0);

        // Reset during CLK_WAIT aborts the RMW
        click_addr_in = 14'h0060; click_in = 1'b1;
        cyc();
        click_in = 1'b0;
        cyc();
        cyc();
        check("rw_wait_addr", 32'(mem_addr_out), 32'h0060);
        rst_in = 1'b1;
        cyc();
        check("rw_addr", 32'(mem_addr_out), 32'h0);
        check("rw_wr", 32'(mem_wr_out), 32'h0);
        check("rw_busy", 32'(busy_out), 32'h0);
        rst_in = 1'b0;
        snap = writes;
        repeat (8) cyc();
        check("rw_nowrite", 32'(writes), 32'(snap));
        check("rw_ram60", 32'(ram[14'h0060]), 32'h0);

        // Reset during STEP clears pending click and tick
        speed_in = 4'd15;
        vsync_in = 1'b0;
        cyc();
        vsync_in = 1'b1;
        cyc();
        cyc();
        step_addr_in = 14'h0123; step_wr_in = 1'b1; step_alive_in = 1'b1;
        click_addr_in = 14'h0070; click_in = 1'b1;
        cyc();
        check("step_addr", 32'(mem_addr_out), 32'h0123);
        check("step_wr", 32'(mem_wr_out), 32'h1);
        check("step_data", 32'(mem_data_out), 32'h1);
        step_wr_in = 1'b0; click_in = 1'b0; vsync_in = 1'b0;
        cyc();
        vsync_in = 1'b1; rst_in = 1'b1;
        cyc();
        check("rs_addr", 32'(mem_addr_out), 32'h0);
        check("rs_wr", 32'(mem_wr_out), 32'h0);
        check("rs_data", 32'(mem_data_out), 32'h0);
        check("rs_busy", 32'(busy_out), 32'h0);
        check("rs_start", 32'(step_start_out), 32'h0);
        rst_in = 1'b0;
        snap = starts;
        repeat (30) cyc();
        check("rs_nostart", 32'(starts), 32'(snap));
        check("rs_ram70", 32'(ram[14'h0070]), 32'h0);
        check("rs_idle", 32'(busy_out), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
